des_perm_pipe: RTL and testbench
================================

// Module: des_perm_pipe
// PURPOSE
//  Parametrised, pipelined successor to the combinational DES P-box.
//  - Applies the DES P permutation, its inverse, or a bypass to LANES independent 32-bit words.
//  - Runs over STAGES elastic register slots with a valid/ready handshake.
//  - Sits between the S-box output and the round XOR, and serves as a standalone verify-path
//    inverse unit. Also keeps a saturating count of delivered beats.
// PARAMETERS
//  LANES   1   number of 32-bit words permuted per beat (1..8)
//  STAGES  2   register slots between input and output (1..4); latency = STAGES cycles
//  CNT_W   16  width of beat counter
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         input beat valid
//  in_ready   out  1         unit can accept input this cycle
//  in_mode    in   2         0=P, 1=P inverse, 2=bypass, 3=reserved
//  in_data    in   32*LANES  lane k = in_data[32k+31:32k]
//  out_valid  out  1         output beat valid
//  out_ready  in   1         downstream accepts output
//  out_data   out  32*LANES  permuted words, same lane layout
//  out_err    out  1         beat was issued with in_mode==3 (travels with data)
//  beat_cnt   out  CNT_W     beats delivered (out_valid&&out_ready), saturating
//  cnt_clr    in   1         synchronous clear of beat_cnt
// BEHAVIOUR
//  Bit numbering:
//   - Within a lane, DES bit n (1..32) = lane bit [32-n]; DES bit 1 = lane MSB.
//   - P: out bit i = in bit T[i], with T = 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10
//     2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
//   - P inverse: out bit T[i] = in bit i.
//   - Bypass: out = in. Mode 3 behaves as bypass with out_err=1.
//  Datapath:
//   - Permutation is combinational ahead of slot 0. Slots 1..STAGES-1 are plain registers.
//   - Each slot holds {valid, err, data}.
//   - Mode is sampled per beat; beats carrying different modes may be in flight together.
//  Handshake:
//   - Transfer occurs when valid && ready on the same edge.
//   - Slot s loads when it is empty or slot s+1 (or the output) advances this cycle.
//   - in_ready = slot 0 can load. It is combinational from out_ready through the slot chain.
//   - out_valid and out_data come from the last slot only. They hold stable while
//     out_valid && !out_ready.
//   - No beat is dropped or duplicated.
//   - With out_ready held 1, there are no bubbles: one beat per cycle, latency STAGES.
//   - Full: all slots valid and out_ready=0 -> in_ready=0. An in_valid beat waits upstream.
//   - Empty: out_valid=0, and out_data holds its last value (don't-care).
//  Counter:
//   - beat_cnt increments on each output transfer and saturates at 2^CNT_W-1.
//   - If cnt_clr and a transfer occur in the same cycle, the clear wins (result 0).
//  Reset:
//   - Async assert clears all slot valids, out_err, and beat_cnt. out_data resets to 0.
//   - Reset mid-stream discards in-flight beats.
//   - in_ready=1 from the first edge after deassert.
// TESTING
//  1 LANES=1, mode 0, in=32'h8000_0000 -> out=32'h0080_0000 after STAGES cycles.
//    Also in=32'hFFFF_FFFF -> out=32'hFFFF_FFFF.
//  2 Mode 1 on 32'h0080_0000 -> 32'h8000_0000. Random stream: mode0 then mode1 chained
//    returns the input, 1000 words.
//  3 Back-to-back 8 beats with out_ready=1 -> 8 outputs on 8 consecutive cycles, beat_cnt=8.
//  4 Hold out_ready=0 until full -> in_ready=0 after STAGES beats and out_data stable.
//    Release -> ordered drain with no loss.
//  5 Mode 3 beat among mode 0 beats -> only that beat has out_err=1, data unchanged.
//    cnt_clr coincident with a transfer -> beat_cnt=0.
//  6 Assert rst_n=0 with 2 beats in flight -> out_valid=0, beat_cnt=0 immediately.
//    No stale beat appears after release.

Source files
------------

// File: rtl/des_perm_pipe.sv
// des_perm_pipe
//   Pipelined DES P-box. Applies P, P inverse or a bypass to LANES independent
//   32-bit words and carries the result through STAGES elastic register slots
//   under a valid/ready handshake. It also keeps a saturating count of
//   delivered beats.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   unit can accept an input beat this cycle
//   in_mode    0 = P, 1 = P inverse, 2 = bypass, 3 = bypass flagged as error
//   in_data    LANES words; lane k = in_data[32k+31:32k]
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   out_data   permuted words, same lane layout as in_data
//   out_err    current output beat was issued with in_mode == 3
//   beat_cnt   delivered beats (out_valid && out_ready), saturating
//   cnt_clr    synchronous clear of beat_cnt; takes priority over a count
module des_perm_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [32*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic                  out_err,
  output logic [CNT_W-1:0]      beat_cnt,
  input  logic                  cnt_clr
);

  localparam int W = 32 * LANES;

  // DES P table: output DES bit i (1-based) takes input DES bit P_TABLE[i-1].
  // DES bit n lives at lane bit [32-n], so DES bit 1 is the lane MSB.
  localparam int P_TABLE [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                   1, 15, 23, 26,  5, 18, 31, 10,
                                   2,  8, 24, 14, 32, 27,  3,  9,
                                  19, 13, 30,  6, 22, 11,  4, 25};

  logic [W-1:0] perm_p;
  logic [W-1:0] perm_inv;
  logic [W-1:0] perm_data;

  genvar gi, gj;

  // Pure wiring: every lane gets the same bit shuffle.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      for (gj = 0; gj < 32; gj++) begin : g_bit
        assign perm_p[32*gi + 31 - gj]               = in_data[32*gi + 32 - P_TABLE[gj]];
        assign perm_inv[32*gi + 32 - P_TABLE[gj]]    = in_data[32*gi + 31 - gj];
      end
    end
  endgenerate

  always_comb begin
    perm_data = in_data;
    case (in_mode)
      2'd0:    perm_data = perm_p;
      2'd1:    perm_data = perm_inv;
      default: perm_data = in_data;
    endcase
  end

  // Slot chain. Slot 0 receives the permuted input, the last slot drives the
  // output. A slot loads when it is empty or its content moves on this cycle,
  // so the ready chain is combinational from out_ready back to in_ready.
  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] err_vec;
  logic [STAGES-1:0] can_load;
  logic [W-1:0]      data_vec [STAGES];

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slot
      logic         take;
      logic         src_valid;
      logic         src_err;
      logic [W-1:0] src_data;
      logic         slot_valid_reg;
      logic         slot_err_reg;
      logic [W-1:0] slot_data_reg;

      if (gi == STAGES - 1) begin : g_last
        assign take = out_ready;
      end else begin : g_mid
        assign take = can_load[gi+1];
      end

      if (gi == 0) begin : g_first
        assign src_valid = in_valid;
        assign src_err   = (in_mode == 2'd3);
        assign src_data  = perm_data;
      end else begin : g_chain
        assign src_valid = valid_vec[gi-1];
        assign src_err   = err_vec[gi-1];
        assign src_data  = data_vec[gi-1];
      end

      assign can_load[gi] = !slot_valid_reg || take;

      // Data only updates when a real beat arrives, so an empty slot keeps
      // its last contents and out_data holds while idle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_valid_reg <= 1'b0;
          slot_err_reg   <= 1'b0;
          slot_data_reg  <= '0;
        end else if (can_load[gi]) begin
          slot_valid_reg <= src_valid;
          if (src_valid) begin
            slot_err_reg  <= src_err;
            slot_data_reg <= src_data;
          end
        end
      end

      assign valid_vec[gi] = slot_valid_reg;
      assign err_vec[gi]   = slot_err_reg;
      assign data_vec[gi]  = slot_data_reg;
    end
  endgenerate

  assign in_ready  = can_load[0];
  assign out_valid = valid_vec[STAGES-1];
  assign out_data  = data_vec[STAGES-1];
  assign out_err   = valid_vec[STAGES-1] && err_vec[STAGES-1];

  // Delivered-beat counter.
  logic             fire;
  logic [CNT_W-1:0] beat_cnt_reg;

  assign fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg <= '0;
    end else if (cnt_clr) begin
      beat_cnt_reg <= '0;
    end else if (fire && (beat_cnt_reg != {CNT_W{1'b1}})) begin
      beat_cnt_reg <= beat_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign beat_cnt = beat_cnt_reg;

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb_des_perm_pipe
//   Directed bench for des_perm_pipe with LANES=1, STAGES=2, CNT_W=16.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_des_perm_pipe;

  localparam int LANES  = 1;
  localparam int STAGES = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic [31:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_err;
  logic [CNT_W-1:0]  beat_cnt;
  logic              cnt_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  des_perm_pipe #(.LANES(LANES), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .beat_cnt  (beat_cnt),
    .cnt_clr   (cnt_clr)
  );

  // Hand-computed single-word vectors.
  logic [1:0]  t_mode [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
  logic [31:0] t_in   [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000,
                              32'h0000_0001, 32'h0080_0000, 32'h8000_0000};
  logic [31:0] t_exp  [6] = '{32'h0080_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'h0000_0800, 32'h8000_0000, 32'h0001_0000};

  // Stream stimulus shared by run_stream.
  logic [1:0]  s_mode [8];
  logic [31:0] s_data [8];
  logic [31:0] s_exp  [8];
  logic        s_err  [8];
  int          rx;
  int          first_cyc;
  int          last_cyc;

  logic [31:0] o;
  logic [31:0] r;
  logic [31:0] d;
  logic        e;
  int          lat;
  int          acc;
  int          stale;
  logic [31:0] q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One beat through an otherwise empty pipe with out_ready=1. Returns at the
  // falling edge where the result is visible; it transfers on the next edge.
  task automatic xfer(input logic [1:0] mode, input logic [31:0] data,
                      output logic [31:0] obs, output logic obs_err, output int wait_n);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = mode;
    in_data   = data;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $error("FAIL xfer_timeout: observed no out_valid expected out_valid within 20 cycles");
    end
    obs     = out_data;
    obs_err = out_err;
    wait_n  = n;
  endtask

  // Drives n beats on consecutive cycles with out_ready=1 and checks each
  // delivered beat in order.
  task automatic run_stream(input int n, input string tag);
    rx        = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int cyc = 0; cyc < n + 12; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid) begin
        if (rx < n) begin
          chk({tag, "_data"}, out_data, s_exp[rx]);
          chk({tag, "_err"}, 32'(out_err), 32'(s_err[rx]));
        end else begin
          chk({tag, "_extra_beat"}, 32'(rx), 32'(n - 1));
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        rx++;
      end
      if (cyc < n) begin
        in_valid = 1'b1;
        in_mode  = s_mode[cyc];
        in_data  = s_data[cyc];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_data   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed single words, P and P inverse.
    for (int i = 0; i < 6; i++) begin
      xfer(t_mode[i], t_in[i], o, e, lat);
      $display("single %0d: mode=%0d in=%h out=%h err=%0d", i, t_mode[i], t_in[i], o, e);
      chk("single_data", o, t_exp[i]);
      chk("single_err", 32'(e), 32'd0);
      chk("single_latency", 32'(lat), 32'(STAGES - 1));
    end

    // P followed by P inverse returns the original word.
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      xfer(2'd0, d, o, e, lat);
      xfer(2'd1, o, r, e, lat);
      $display("roundtrip %0d: in=%h p=%h back=%h", i, d, o, r);
      chk("roundtrip", r, d);
    end
    @(negedge clk);
    chk("count_after_singles", 32'(beat_cnt), 32'd46);

    // Clear, then 8 back-to-back bypass beats.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr", 32'(beat_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      s_mode[i] = 2'd2;
      s_data[i] = 32'hA500_0000 + 32'(i);
      s_exp[i]  = 32'hA500_0000 + 32'(i);
      s_err[i]  = 1'b0;
    end
    run_stream(8, "b2b");
    $display("b2b: beats=%0d first=%0d last=%0d cnt=%0d", rx, first_cyc, last_cyc, beat_cnt);
    chk("b2b_beats", 32'(rx), 32'd8);
    chk("b2b_span", 32'(last_cyc - first_cyc), 32'd7);
    chk("b2b_cnt", 32'(beat_cnt), 32'd8);

    // Fill with out_ready=0, check stall and hold, then drain in order.
    q.delete();
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = 2'd2;
      in_data  = 32'hB000_0000 + 32'(acc);
      if (in_ready) begin
        q.push_back(in_data);
        acc++;
      end
    end
    chk("fill_count", 32'(acc), 32'(STAGES));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    o = out_data;
    repeat (3) @(negedge clk);
    $display("full: held out=%h now=%h in_ready=%0d", o, out_data, in_ready);
    chk("hold_first", o, 32'hB000_0000);
    chk("hold_data", out_data, o);
    chk("hold_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    if (in_ready) begin
      q.push_back(in_data);
      acc++;
    end
    rx = 0;
    if (out_valid) begin
      r = q.pop_front();
      chk("drain_data", out_data, r);
      rx++;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        if (q.size() > 0) begin
          r = q.pop_front();
          $display("drain: out=%h exp=%h", out_data, r);
          chk("drain_data", out_data, r);
        end else begin
          chk("drain_extra", out_data, 32'hFFFF_FFFF ^ out_data);
        end
        rx++;
      end
    end
    chk("drain_count", 32'(rx), 32'd3);
    chk("drain_left", 32'(q.size()), 32'd0);
    chk("drain_cnt", 32'(beat_cnt), 32'd11);

    // Mode 3 beat between mode 0 beats.
    s_mode[0] = 2'd0; s_data[0] = 32'h8000_0000; s_exp[0] = 32'h0080_0000; s_err[0] = 1'b0;
    s_mode[1] = 2'd3; s_data[1] = 32'h8000_0000; s_exp[1] = 32'h8000_0000; s_err[1] = 1'b1;
    s_mode[2] = 2'd0; s_data[2] = 32'h8000_0000; s_exp[2] = 32'h0080_0000; s_err[2] = 1'b0;
    run_stream(3, "mode3");
    $display("mode3: beats=%0d cnt=%0d", rx, beat_cnt);
    chk("mode3_beats", 32'(rx), 32'd3);
    chk("mode3_cnt", 32'(beat_cnt), 32'd14);

    // Clear coincident with a transfer: clear wins.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd2;
    in_data   = 32'hC0DE_0001;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    $display("clr+xfer: cnt=%0d out_valid=%0d", beat_cnt, out_valid);
    chk("clr_wins", 32'(beat_cnt), 32'd0);
    chk("clr_beat_gone", 32'(out_valid), 32'd0);

    // Reset with two beats in flight.
    xfer(2'd2, 32'h1234_5678, o, e, lat);
    @(negedge clk);
    chk("pre_rst_cnt", 32'(beat_cnt), 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_data   = 32'hDEAD_0001;
    @(negedge clk);
    in_data = 32'hDEAD_0002;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: out_valid=%0d cnt=%0d out=%h", out_valid, beat_cnt, out_data);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("arst_out_data", out_data, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_beat", 32'(stale), 32'd0);
    chk("post_arst_in_ready", 32'(in_ready), 32'd1);
    xfer(2'd0, 32'h8000_0000, o, e, lat);
    $display("after reset: out=%h", o);
    chk("post_arst_data", o, 32'h0080_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
